// File: rtl/riscv_perf_counters.sv
// Event counters for the CPU+memory top level with an IDLE/RUN/HALTED run-control FSM
// and a one-cycle-latency read port. Define PERF_SATURATE_EN to saturate instead of wrap.
module riscv_perf_counters #(
  parameter int CNT_W   = 32,
  parameter int NUM_CNT = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stat_beq,
  input  logic               stat_bne,
  input  logic               stat_blt,
  input  logic               stat_bge,
  input  logic               stat_bltu,
  input  logic               stat_bgeu,
  input  logic               stat_jal,
  input  logic               stat_jalr,
  input  logic               stat_PL_flush,
  input  logic               unknown_instr_warning_main_decode,
  input  logic               Rd_x_warning_ram,
  input  logic               start,
  input  logic               stop,
  input  logic               clr,
  input  logic               rd_req,
  input  logic [3:0]         rd_sel,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_CNT-1:0] ovf,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]   r_cnt [NUM_CNT];
  logic [NUM_CNT-1:0] r_ovf;
  logic               r_rd_valid;
  logic [CNT_W-1:0]   r_rd_data;

  logic               w_run;
  logic [11:0]        w_evt;
  logic [NUM_CNT-1:0] w_inc;
  logic [CNT_W-1:0]   w_rd_val;

  // Priority on coincident pulses: clr > stop > warning-halt > start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!clr && !stop && start) w_next = S_RUN;
      S_RUN: begin
        if (clr)                                    w_next = S_RUN;
        else if (stop)                              w_next = S_IDLE;
        else if (unknown_instr_warning_main_decode) w_next = S_HALTED;
      end
      S_HALTED: if (clr) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  assign w_run = (r_state == S_RUN);

  // Bit order follows the counter index map; bit 9 is the run-cycle counter.
  assign w_evt = {Rd_x_warning_ram, unknown_instr_warning_main_decode, 1'b1,
                  stat_PL_flush, stat_jalr, stat_jal, stat_bgeu, stat_bltu,
                  stat_bge, stat_blt, stat_bne, stat_beq};

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_inc
    if (g < 12) begin : g_map
      assign w_inc[g] = w_run & w_evt[g];
    end else begin : g_none
      assign w_inc[g] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_inc[i]) begin
          if (&r_cnt[i]) begin
            r_ovf[i] <= 1'b1;
`ifdef PERF_SATURATE_EN
            r_cnt[i] <= r_cnt[i];
`else
            r_cnt[i] <= '0;
`endif
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == 4'(i)) w_rd_val = r_cnt[i];
    end
  end

  // Read handshake: rd_req sampled on an edge yields rd_valid=1 for exactly the following
  // cycle with the pre-edge counter value; no backpressure, rd_data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) r_rd_data <= w_rd_val;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign ovf      = r_ovf;
  assign state    = r_state;

endmodule

// File: tb/tb_riscv_perf_counters.sv
// Bench for riscv_perf_counters: directed test-plan scenarios plus random traffic,
// all checked against an unbounded-count reference model.
module tb_riscv_perf_counters;

  localparam int CW   = 8;
  localparam int NC   = 12;
  localparam longint MAXV = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic stat_beq, stat_bne, stat_blt, stat_bge, stat_bltu, stat_bgeu;
  logic stat_jal, stat_jalr, stat_PL_flush;
  logic unknown_instr_warning_main_decode, Rd_x_warning_ram;
  logic start, stop, clr, rd_req;
  logic [3:0]    rd_sel;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic [NC-1:0] ovf;
  logic [1:0]    state;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: total increments since last clear, decoded to a value on demand.
  int            m_state;
  longint        m_tot [NC];
  logic          m_rd_valid;
  logic [CW-1:0] m_rd_data;

  always #5 clk = ~clk;

  riscv_perf_counters #(.CNT_W(CW), .NUM_CNT(NC)) u_dut (
    .clk                               (clk),
    .rst                               (rst),
    .stat_beq                          (stat_beq),
    .stat_bne                          (stat_bne),
    .stat_blt                          (stat_blt),
    .stat_bge                          (stat_bge),
    .stat_bltu                         (stat_bltu),
    .stat_bgeu                         (stat_bgeu),
    .stat_jal                          (stat_jal),
    .stat_jalr                         (stat_jalr),
    .stat_PL_flush                     (stat_PL_flush),
    .unknown_instr_warning_main_decode (unknown_instr_warning_main_decode),
    .Rd_x_warning_ram                  (Rd_x_warning_ram),
    .start                             (start),
    .stop                              (stop),
    .clr                               (clr),
    .rd_req                            (rd_req),
    .rd_sel                            (rd_sel),
    .rd_valid                          (rd_valid),
    .rd_data                           (rd_data),
    .ovf                               (ovf),
    .state                             (state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] mval(input int i);
    longint v;
`ifdef PERF_SATURATE_EN
    v = (m_tot[i] > MAXV) ? MAXV : m_tot[i];
`else
    v = m_tot[i] % (MAXV + 1);
`endif
    return v[CW-1:0];
  endfunction

  function automatic logic [NC-1:0] movf();
    logic [NC-1:0] o;
    for (int i = 0; i < NC; i++) o[i] = (m_tot[i] > MAXV);
    return o;
  endfunction

  task automatic model_reset();
    m_state    = 0;
    m_rd_valid = 1'b0;
    m_rd_data  = '0;
    for (int i = 0; i < NC; i++) m_tot[i] = 0;
  endtask

  task automatic model_edge();
    logic [NC-1:0] ev;
    ev = {Rd_x_warning_ram, unknown_instr_warning_main_decode, 1'b1, stat_PL_flush,
          stat_jalr, stat_jal, stat_bgeu, stat_bltu, stat_bge, stat_blt, stat_bne, stat_beq};
    m_rd_valid = rd_req;
    if (rd_req) m_rd_data = (int'(rd_sel) < NC) ? mval(int'(rd_sel)) : '0;
    if (clr) begin
      for (int i = 0; i < NC; i++) m_tot[i] = 0;
    end else if (m_state == 1) begin
      for (int i = 0; i < NC; i++) if (ev[i]) m_tot[i]++;
    end
    if (clr) begin
      if (m_state == 2) m_state = 0;
    end else if (stop) begin
      if (m_state == 1) m_state = 0;
    end else if (unknown_instr_warning_main_decode && m_state == 1) begin
      m_state = 2;
    end else if (start && m_state == 0) begin
      m_state = 1;
    end
  endtask

  task automatic zero_inputs();
    stat_beq = 0; stat_bne = 0; stat_blt = 0; stat_bge = 0; stat_bltu = 0;
    stat_bgeu = 0; stat_jal = 0; stat_jalr = 0; stat_PL_flush = 0;
    unknown_instr_warning_main_decode = 0; Rd_x_warning_ram = 0;
    start = 0; stop = 0; clr = 0; rd_req = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", 64'(state), 64'(m_state));
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    chk("rd_data", 64'(rd_data), 64'(m_rd_data));
    chk("ovf", 64'(ovf), 64'(movf()));
  endtask

  task automatic pulse_start();
    start = 1; cycle(); start = 0;
  endtask

  task automatic pulse_clr();
    clr = 1; cycle(); clr = 0;
  endtask

  task automatic do_read(input int sel);
    rd_req = 1; rd_sel = 4'(sel); cycle(); rd_req = 0;
  endtask

  initial begin
    zero_inputs();
    rd_sel = '0;
    rst = 1;
    model_reset();
    #1;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // 5 beq, 3 jalr over 20 RUN cycles, stop on the last one
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      stat_beq  = (k < 5);
      stat_jalr = (k % 7 == 1);
      stop      = (k == 19);
      cycle();
    end
    zero_inputs();
    chk("stopped_state", 64'(state), 64'd0);
    do_read(0); chk("beq_cnt", 64'(rd_data), 64'd5);
    do_read(7); chk("jalr_cnt", 64'(rd_data), 64'd3);
    do_read(9); chk("cyc_cnt", 64'(rd_data), 64'd20);

    // all nine stat inputs at once
    pulse_clr();
    pulse_start();
    stat_beq = 1; stat_bne = 1; stat_blt = 1; stat_bge = 1; stat_bltu = 1;
    stat_bgeu = 1; stat_jal = 1; stat_jalr = 1; stat_PL_flush = 1;
    cycle();
    zero_inputs();
    stop = 1; cycle(); stop = 0;
    for (int i = 0; i < 9; i++) begin
      do_read(i);
      chk($sformatf("all_stat_%0d", i), 64'(rd_data), 64'd1);
    end
    do_read(13);
    chk("sel13_data", 64'(rd_data), 64'd0);
    chk("sel13_valid", 64'(rd_valid), 64'd1);

    // warning halt freezes counters until clr
    pulse_clr();
    pulse_start();
    unknown_instr_warning_main_decode = 1; stat_bne = 1;
    cycle();
    zero_inputs();
    chk("halt_state", 64'(state), 64'd2);
    do_read(10); chk("warn_cnt", 64'(rd_data), 64'd1);
    do_read(1);  chk("bne_cnt", 64'(rd_data), 64'd1);
    start = 1;
    for (int k = 0; k < 10; k++) begin
      stat_bne = 1; cycle(); stat_bne = 0; cycle();
    end
    start = 0;
    do_read(1); chk("bne_frozen", 64'(rd_data), 64'd1);
    chk("still_halted", 64'(state), 64'd2);
    pulse_clr();
    chk("clr_idle", 64'(state), 64'd0);
    for (int i = 0; i < 16; i++) begin
      do_read(i);
      chk($sformatf("cleared_%0d", i), 64'(rd_data), 64'd0);
    end

    // run-cycle counter reaching all-ones, then one more increment
    pulse_clr();
    pulse_start();
    repeat (int'(MAXV) - 1) cycle();
    stop = 1; cycle(); stop = 0;
    do_read(9);
    chk("cyc_full", 64'(rd_data), 64'(MAXV));
    chk("ovf_before", 64'(ovf[9]), 64'd0);
    pulse_start();
    stop = 1; cycle(); stop = 0;
    do_read(9);
`ifdef PERF_SATURATE_EN
    chk("cyc_sat", 64'(rd_data), 64'(MAXV));
`else
    chk("cyc_wrap", 64'(rd_data), 64'd0);
`endif
    chk("ovf_after", 64'(ovf[9]), 64'd1);

    // read coinciding with clr returns pre-clear value
    pulse_clr();
    chk("ovf_cleared", 64'(ovf), 64'd0);
    pulse_start();
    repeat (7) cycle();
    clr = 1; rd_req = 1; rd_sel = 4'd9;
    cycle();
    zero_inputs();
    chk("rd_clr_data", 64'(rd_data), 64'd7);
    chk("rd_clr_state", 64'(state), 64'd1);
    cycle();
    do_read(9); chk("after_clr", 64'(rd_data), 64'd1);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      stat_beq      = ($urandom_range(0, 3) == 0);
      stat_bne      = ($urandom_range(0, 3) == 0);
      stat_blt      = ($urandom_range(0, 3) == 0);
      stat_bge      = ($urandom_range(0, 3) == 0);
      stat_bltu     = ($urandom_range(0, 3) == 0);
      stat_bgeu     = ($urandom_range(0, 3) == 0);
      stat_jal      = ($urandom_range(0, 3) == 0);
      stat_jalr     = ($urandom_range(0, 3) == 0);
      stat_PL_flush = ($urandom_range(0, 3) == 0);
      Rd_x_warning_ram                  = ($urandom_range(0, 3) == 0);
      unknown_instr_warning_main_decode = ($urandom_range(0, 29) == 0);
      start  = ($urandom_range(0, 7) == 0);
      stop   = ($urandom_range(0, 24) == 0);
      clr    = ($urandom_range(0, 39) == 0);
      rd_req = ($urandom_range(0, 1) == 0);
      rd_sel = 4'($urandom_range(0, 15));
      cycle();
    end
    zero_inputs();

    // asynchronous reset in the middle of a run
    pulse_clr();
    pulse_start();
    stat_beq = 1; repeat (5) cycle(); stat_beq = 0;
    rd_req = 1; rd_sel = 4'd0;
    #2;
    rst = 1;
    #1;
    chk("arst_valid", 64'(rd_valid), 64'd0);
    chk("arst_data", 64'(rd_data), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    chk("arst_state", 64'(state), 64'd0);
    zero_inputs();
    model_reset();
    @(negedge clk);
    rst = 0;
    pulse_start();
    do_read(0); chk("arst_beq", 64'(rd_data), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_perf_counters.md
Name: riscv_perf_counters

Overview:
- Event-counting stage downstream of the CPU+memory top level. Consumes its single-cycle stat_* pulses and warning strobes.
- Accumulates per-event counts plus a run-cycle count, under a small run-control FSM.
- Exposes counts through a one-cycle-latency read port used by the testbench or a debug host.
- Sits beside the top level and feeds nothing back into the pipeline.

Parameters:
- CNT_W, 32: width of every counter and of rd_data.
- NUM_CNT, 12: number of implemented counters. Fixed map below; indices NUM_CNT..15 read as zero.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stat_beq, stat_bne, stat_blt, stat_bge, stat_bltu, stat_bgeu, stat_jal, stat_jalr, stat_PL_flush  in  1 each  single-cycle event pulses
- unknown_instr_warning_main_decode  in  1  decoder warning strobe
- Rd_x_warning_ram  in  1  RAM X-read warning strobe
- start  in  1  pulse: begin counting
- stop  in  1  pulse: pause counting
- clr  in  1  pulse: zero all counters and overflow flags
- rd_req  in  1  read request
- rd_sel  in  4  counter index to read
- rd_valid  out  1  read data valid
- rd_data  out  CNT_W  counter value
- ovf  out  NUM_CNT  sticky per-counter overflow flags
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 HALTED

Behaviour:
- Reset (async, rst=1): all counters 0, ovf 0, rd_valid 0, rd_data 0, state IDLE.
- Counter map:
  - 0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu
  - 6 jal, 7 jalr, 8 PL_flush
  - 9 cycles (+1 every clk in RUN)
  - 10 unknown_instr warnings, 11 Rd_x warnings
- Counters increment only in RUN, by +1 per cycle their input is high. Multiple inputs high in the same cycle each increment their own counter.
- FSM (all transitions on the clock edge):
  - IDLE: start goes to RUN.
  - RUN: stop goes to IDLE. unknown_instr_warning_main_decode=1 goes to HALTED; that cycle's events, including counter 10, are still counted.
  - HALTED: counters frozen, start ignored. clr goes to IDLE.
  - Priority when pulses coincide: clr > stop > warning-halt > start.
  - start while in RUN has no effect; stop while in IDLE has no effect.
- clr:
  - Zeros every counter and ovf on the next edge. Same-cycle increments are discarded.
  - State: RUN stays RUN, HALTED goes to IDLE.
- Wrap: a counter at all-ones that increments wraps to 0 and sets its ovf bit, which stays set until clr or rst.
- Read handshake:
  - rd_req sampled at edge N. On edge N the block registers rd_valid=1 and rd_data = that counter's value before the edge-N increment.
  - rd_valid is a single-cycle pulse per request. Back-to-back requests give back-to-back valid cycles.
  - rd_req=0 gives rd_valid=0; rd_data holds its last value.
  - rd_sel >= NUM_CNT returns 0 with rd_valid=1.
  - Read and clr in the same cycle return the pre-clear value.
- Reset asserted mid-operation: all state cleared immediately and asynchronously. No partial read completes.

Optional Feature:
- Macro: PERF_SATURATE_EN.
- Defined: counters saturate at all-ones instead of wrapping. The ovf bit sets on the first increment attempted at all-ones; the counter holds all-ones.
- Undefined: wrap-around behaviour as specified above.

Test Plan:
- rst, start, then 5 stat_beq pulses and 3 stat_jalr pulses over 20 RUN cycles, then stop. Read sel 0, 7, 9 -> 5, 3, 20; state=0.
- In RUN, all 9 stat inputs high for one cycle -> counters 0..8 each read 1. Read sel 13 -> rd_data=0, rd_valid=1.
- In RUN, assert unknown_instr_warning for one cycle together with stat_bne -> state=2, counters 10=1 and 1=1. A further 10 stat_bne pulses leave counter 1=1. Then clr -> state=0, all reads 0.
- Force counter 9 to all-ones (CNT_W=4 build, run 15 cycles), then 1 more cycle -> rd_data=0 and ovf[9]=1. Under PERF_SATURATE_EN -> rd_data=15 and ovf[9]=1.
- rd_req with sel=9 in the same cycle as clr while in RUN (counter 9 = 7) -> rd_data=7, next read returns 1.
- Assert rst mid-RUN with counters nonzero -> outputs zero without a clock edge; state=0.
